// File: rtl/rotary_position_if.sv
// Bus side of rotary_position: two-register map with a one-cycle ack.
// The master drives the strobes; the slave returns read_data and ack.
interface rotary_position_if;
   logic        address;
   logic        read;
   logic        write;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ack;

   modport master (output address, read, write, write_data, input read_data, ack);
   modport slave  (input address, read, write, write_data, output read_data, ack);
endinterface

// File: rtl/rotary_position.sv
// Bounded absolute position and signed delta-since-read, fed by debounced detents.
// Define ROTARY_ACCEL_EN to add the fast-spin 4x step acceleration.
module rotary_position #(
   parameter int WIDTH    = 8,
   parameter int MIN_POS  = 0,
   parameter int MAX_POS  = 255,
   parameter int INIT_POS = 0,
   parameter int STEP     = 1,
   parameter int WRAP     = 0
`ifdef ROTARY_ACCEL_EN
   , parameter int ACCEL_WINDOW = 2_500_000
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rotary_event,
   input  logic             rotary_right,
   rotary_position_if.slave bus,
   output logic             interrupt
);

`ifdef ROTARY_ACCEL_EN
   localparam int EW = WIDTH + 4;
`else
   localparam int EW = WIDTH + 2;
`endif
   typedef logic signed [EW-1:0] ext_t;
   localparam ext_t MIN_X = ext_t'(MIN_POS);
   localparam ext_t MAX_X = ext_t'(MAX_POS);

   logic [WIDTH-1:0]  position;
   logic [WIDTH-1:0]  move_pos;
   logic [WIDTH-1:0]  wr_pos;
   logic signed [7:0] delta;
   logic signed [7:0] delta_base;
   logic signed [7:0] delta_next;
   logic              pending;
   logic              accel;
   logic              pos_wr;
   logic              clr;
   logic [31:0]       rd_val;
   ext_t              pos_x;
   ext_t              step_x;
   ext_t              next_x;

`ifdef ROTARY_ACCEL_EN
   localparam int CW = $clog2(ACCEL_WINDOW + 1);
   logic [CW-1:0] gap;

   assign accel = gap < CW'(ACCEL_WINDOW);

   always_ff @(posedge clock) begin
      if (reset)             gap <= CW'(ACCEL_WINDOW);
      else if (rotary_event) gap <= '0;
      else if (accel)        gap <= gap + CW'(1);
   end
`else
   assign accel = 1'b0;
`endif

   assign step_x    = accel ? ext_t'(4 * STEP) : ext_t'(STEP);
   assign pos_wr    = bus.write & ~bus.address;
   assign clr       = (bus.read & ~bus.write & bus.address) |
                      (bus.write & bus.address & bus.write_data[9]);
   assign interrupt = pending;

   always_comb begin
      pos_x  = ext_t'({{(EW-WIDTH){1'b0}}, position});
      next_x = rotary_right ? pos_x + step_x : pos_x - step_x;
      if (next_x > MAX_X)      move_pos = (WRAP != 0) ? WIDTH'(MIN_POS) : WIDTH'(MAX_POS);
      else if (next_x < MIN_X) move_pos = (WRAP != 0) ? WIDTH'(MAX_POS) : WIDTH'(MIN_POS);
      else                     move_pos = next_x[WIDTH-1:0];
   end

   // Clamp the whole write word so oversize values saturate instead of aliasing.
   always_comb begin
      if (bus.write_data > 32'(MAX_POS))      wr_pos = WIDTH'(MAX_POS);
      else if (bus.write_data < 32'(MIN_POS)) wr_pos = WIDTH'(MIN_POS);
      else                                    wr_pos = bus.write_data[WIDTH-1:0];
   end

   always_comb begin
      delta_base = clr ? 8'sd0 : delta;
      delta_next = delta_base;
      if (rotary_event) begin
         if (rotary_right) delta_next = (delta_base == 8'sd127) ? delta_base : delta_base + 8'sd1;
         else              delta_next = (delta_base == -8'sd128) ? delta_base : delta_base - 8'sd1;
      end
   end

   always_comb begin
      rd_val = '0;
      if (bus.read & ~bus.write)
         rd_val = bus.address ? {22'b0, pending, accel, delta} : 32'(position);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         position      <= WIDTH'(INIT_POS);
         delta         <= '0;
         pending       <= 1'b0;
         bus.read_data <= '0;
         bus.ack       <= 1'b0;
      end else begin
         bus.ack       <= bus.read | bus.write;
         bus.read_data <= rd_val;
         delta         <= delta_next;
         // A detent in the same cycle as a clear leaves pending set.
         pending       <= rotary_event | (pending & ~clr);
         if (pos_wr)            position <= wr_pos;
         else if (rotary_event) position <= move_pos;
      end
   end

endmodule
